// File: rtl/image_feeder.sv
// Purpose : producer side of the CNN image interface; ping-pong buffers byte-stream
//           frames (label beat, then row-major pixels) and presents the front image
//           to the network top, advancing whenever the top's image index changes.
// Latency : last pixel accepted at edge N marks the back buffer full at N; it is
//           swapped in at N+1 when no image is shown, or on the edge where the index
//           changes. Index change at edge N updates the outputs at edge N+1.
// Backpressure: in_ready drops only while a complete frame waits in the back buffer
//               (and during reset); all other beats are accepted every cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   stream handshake; in_data = label (low 4 bits) then pixels
//   in_last             final pixel beat of a frame
//   input_index         consumer's image index; any change is an advance
//   input_data          front image, unsigned pixel scaled into signed fixed point
//   input_labels        front one-hot label in fixed point
//   image_valid         front buffer holds an image
//   underrun            sticky: advance seen while no complete frame was waiting
//   frame_error         sticky: bad label or misplaced in_last
module image_feeder #(
    parameter int WIDTH             = 32,
    parameter int FIXED_POINT_INDEX = 16,
    parameter int INPUT_DIM_WIDTH   = 28,
    parameter int INPUT_DIM_HEIGHT  = 28,
    parameter int FCL_OUTPUT_DIM    = 10,
    parameter int NUM_IMAGES        = 10000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    input  logic                          in_last,
    input  logic [$clog2(NUM_IMAGES)-1:0] input_index,
    output logic [WIDTH-1:0]              input_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
    output logic [WIDTH-1:0]              input_labels [FCL_OUTPUT_DIM],
    output logic                          image_valid,
    output logic                          underrun,
    output logic                          frame_error
);

    localparam int ROW_W     = $clog2(INPUT_DIM_HEIGHT);
    localparam int COL_W     = $clog2(INPUT_DIM_WIDTH);
    localparam int PIX_SHIFT = FIXED_POINT_INDEX - 8;
    localparam logic [WIDTH-1:0] LABEL_ONE = WIDTH'(1) << FIXED_POINT_INDEX;

    typedef enum logic [1:0] {ST_LABEL, ST_PIXELS, ST_DRAIN, ST_FULL} state_t;

    state_t state, state_nxt;

    // Buffers hold raw bytes and one-hot labels; scaling happens on the read side.
    logic [7:0]                pix_mem [2][INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH];
    logic [FCL_OUTPUT_DIM-1:0] lbl_mem [2];

    logic                          front_sel;
    logic                          back_sel;
    logic                          back_full;
    logic [ROW_W-1:0]              row;
    logic [COL_W-1:0]              col;
    logic [$clog2(NUM_IMAGES)-1:0] prev_index;

    logic                      accept;
    logic                      last_px;
    logic                      label_ok;
    logic                      advance;
    logic                      completing;
    logic                      swap;
    logic                      err_set;
    logic                      wr_label;
    logic                      wr_px;
    logic                      full_set;
    logic [FCL_OUTPUT_DIM-1:0] label_oh;

    assign back_sel   = ~front_sel;
    assign in_ready   = !reset && (state != ST_FULL);
    assign accept     = in_valid && in_ready;
    assign last_px    = (row == ROW_W'(INPUT_DIM_HEIGHT - 1)) && (col == COL_W'(INPUT_DIM_WIDTH - 1));
    assign label_ok   = int'(in_data[3:0]) < FCL_OUTPUT_DIM;
    assign advance    = input_index != prev_index;
    assign completing = accept && (state == ST_PIXELS) && last_px && in_last;
    // A frame finishing on the same edge as an advance is swapped straight in;
    // a frame finishing while nothing is shown waits one edge (registered back_full).
    assign swap       = (back_full && !image_valid) || (advance && (back_full || completing));

    always_comb begin
        for (int i = 0; i < FCL_OUTPUT_DIM; i++) begin
            label_oh[i] = (int'(in_data[3:0]) == i);
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        wr_label  = 1'b0;
        wr_px     = 1'b0;
        full_set  = 1'b0;
        case (state)
            ST_LABEL: begin
                if (accept) begin
                    if (!label_ok) begin
                        // Bad label: the rest of this frame is skipped up to in_last.
                        err_set   = 1'b1;
                        state_nxt = in_last ? ST_LABEL : ST_DRAIN;
                    end else begin
                        wr_label  = 1'b1;
                        state_nxt = ST_PIXELS;
                    end
                end
            end
            ST_PIXELS: begin
                if (accept) begin
                    wr_px = 1'b1;
                    if (last_px) begin
                        if (in_last) begin
                            full_set  = 1'b1;
                            state_nxt = swap ? ST_LABEL : ST_FULL;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (in_last) begin
                        err_set   = 1'b1;
                        state_nxt = ST_LABEL;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && in_last) begin
                    state_nxt = ST_LABEL;
                end
            end
            ST_FULL: begin
                if (swap) begin
                    state_nxt = ST_LABEL;
                end
            end
            default: state_nxt = ST_LABEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LABEL;
            front_sel   <= 1'b0;
            back_full   <= 1'b0;
            image_valid <= 1'b0;
            underrun    <= 1'b0;
            frame_error <= 1'b0;
            row         <= '0;
            col         <= '0;
            prev_index  <= input_index;
        end else begin
            state      <= state_nxt;
            prev_index <= input_index;
            if (err_set) begin
                frame_error <= 1'b1;
            end
            if (wr_label) begin
                row <= '0;
                col <= '0;
            end else if (wr_px) begin
                if (col == COL_W'(INPUT_DIM_WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (swap) begin
                front_sel   <= ~front_sel;
                image_valid <= 1'b1;
                back_full   <= 1'b0;
            end else begin
                if (full_set) begin
                    back_full <= 1'b1;
                end
                // Without a swap, an advance means no complete frame was waiting.
                if (advance) begin
                    underrun    <= 1'b1;
                    image_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                lbl_mem[b] <= '0;
                for (int r = 0; r < INPUT_DIM_HEIGHT; r++) begin
                    for (int c = 0; c < INPUT_DIM_WIDTH; c++) begin
                        pix_mem[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            if (wr_label) begin
                lbl_mem[back_sel] <= label_oh;
            end
            if (wr_px) begin
                pix_mem[back_sel][row][col] <= in_data;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < INPUT_DIM_HEIGHT; r++) begin
            for (int c = 0; c < INPUT_DIM_WIDTH; c++) begin
                input_data[r][c] = WIDTH'(pix_mem[front_sel][r][c]) << PIX_SHIFT;
            end
        end
        for (int i = 0; i < FCL_OUTPUT_DIM; i++) begin
            input_labels[i] = lbl_mem[front_sel][i] ? LABEL_ONE : '0;
        end
    end

endmodule

// File: tb/tb_image_feeder.sv
// Purpose : directed self-checking bench for image_feeder.
// Latency : drives inputs and samples outputs 1 ns after each rising edge.
// Backpressure: beat sends wait on in_ready with a bounded cycle budget.
module tb_image_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [13:0] input_index;
    logic [31:0] input_data [28][28];
    logic [31:0] input_labels [10];
    logic        image_valid;
    logic        underrun;
    logic        frame_error;

    int n_cmp = 0;
    int n_err = 0;

    image_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .input_index  (input_index),
        .input_data   (input_data),
        .input_labels (input_labels),
        .image_valid  (image_valid),
        .underrun     (underrun),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) chk("rdy_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Label beat, then npix pixels of value base+step*i; in_last on pixel number last_at (1-based, 0 = never).
    task automatic send_frame(input logic [7:0] lbl, input logic [7:0] base, input logic [7:0] step,
                              input int npix, input int last_at);
        send_beat(lbl, 1'b0);
        for (int i = 0; i < npix; i++) begin
            send_beat(8'(int'(base) + int'(step) * i), (i + 1) == last_at);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        in_last     = 1'b0;
        input_index = 14'd0;
        #1;
        chk("rst_valid", {31'd0, image_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_data", input_data[0][0], 32'd0);
        chk("rst_lbl0", input_labels[0], 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // First image: label 3, all pixels 0x80.
        send_frame(8'd3, 8'h80, 8'd0, 784, 784);
        chk("first_valid_N", {31'd0, image_valid}, 32'd0);
        tick();
        chk("first_valid_N1", {31'd0, image_valid}, 32'd1);
        chk("first_px00", input_data[0][0], 32'h0000_8000);
        chk("first_lbl3", input_labels[3], 32'h0001_0000);
        chk("first_lbl0", input_labels[0], 32'd0);
        chk("first_lbl9", input_labels[9], 32'd0);

        // Image A (label 1, ramp) waits in back buffer while index is unchanged.
        send_frame(8'd1, 8'd1, 8'd1, 784, 784);
        chk("A_held_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("A_held_front", input_labels[3], 32'h0001_0000);
        input_index = 14'd1;
        tick();
        chk("A_lbl1", input_labels[1], 32'h0001_0000);
        chk("A_lbl3", input_labels[3], 32'd0);
        chk("A_ready", {31'd0, in_ready}, 32'd1);
        chk("A_px01", input_data[0][1], 32'h0000_0200);
        chk("A_px2727", input_data[27][27], 32'h0000_1000);
        chk("A_underrun", {31'd0, underrun}, 32'd0);

        // Image B (label 7) swaps in on the next index step.
        send_frame(8'd7, 8'h10, 8'd0, 784, 784);
        chk("B_held_ready", {31'd0, in_ready}, 32'd0);
        input_index = 14'd2;
        tick();
        chk("B_lbl7", input_labels[7], 32'h0001_0000);
        chk("B_px55", input_data[5][5], 32'h0000_1000);
        chk("B_underrun", {31'd0, underrun}, 32'd0);

        // Advance with nothing loaded: underrun, then recovery with image C.
        input_index = 14'd3;
        tick();
        chk("ur_flag", {31'd0, underrun}, 32'd1);
        chk("ur_valid", {31'd0, image_valid}, 32'd0);
        chk("ur_front_kept", input_labels[7], 32'h0001_0000);
        send_frame(8'd5, 8'h40, 8'd0, 784, 784);
        chk("C_valid_N", {31'd0, image_valid}, 32'd0);
        tick();
        chk("C_valid_N1", {31'd0, image_valid}, 32'd1);
        chk("C_lbl5", input_labels[5], 32'h0001_0000);
        chk("C_px00", input_data[0][0], 32'h0000_4000);
        chk("pre_err_flag", {31'd0, frame_error}, 32'd0);

        // Out-of-range label: frame discarded, then image D loads normally.
        send_beat(8'd12, 1'b0);
        chk("badlbl_err", {31'd0, frame_error}, 32'd1);
        for (int i = 0; i < 784; i++) send_beat(8'hEE, i == 783);
        chk("badlbl_ready", {31'd0, in_ready}, 32'd1);
        chk("badlbl_front", input_labels[5], 32'h0001_0000);
        send_frame(8'd2, 8'h22, 8'd0, 784, 784);
        chk("D_held_ready", {31'd0, in_ready}, 32'd0);
        input_index = 14'd4;
        tick();
        chk("D_lbl2", input_labels[2], 32'h0001_0000);
        chk("D_px00", input_data[0][0], 32'h0000_2200);

        // Early in_last at pixel 100: frame dropped, front unchanged.
        send_frame(8'd6, 8'h33, 8'd0, 100, 100);
        chk("early_ready", {31'd0, in_ready}, 32'd1);
        chk("early_front", input_labels[2], 32'h0001_0000);
        chk("early_valid", {31'd0, image_valid}, 32'd1);

        // Missing in_last on pixel 784: drain up to the next in_last.
        send_frame(8'd8, 8'h44, 8'd0, 784, 0);
        chk("nolast_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) send_beat(8'h99, i == 2);
        tick(); tick();
        chk("nolast_front", input_labels[2], 32'h0001_0000);
        chk("nolast_lbl8", input_labels[8], 32'd0);
        send_frame(8'd9, 8'h55, 8'd0, 784, 784);
        input_index = 14'd5;
        tick();
        chk("E_lbl9", input_labels[9], 32'h0001_0000);
        chk("E_px1020", input_data[10][20], 32'h0000_5500);

        // Reset mid-frame at pixel 400.
        send_frame(8'd4, 8'h77, 8'd0, 400, 0);
        reset = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, image_valid}, 32'd0);
        chk("mrst_lbl9", input_labels[9], 32'd0);
        chk("mrst_data", input_data[10][20], 32'd0);
        chk("mrst_err", {31'd0, frame_error}, 32'd0);
        chk("mrst_ur", {31'd0, underrun}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd0);
        input_index = 14'd9999;
        tick(); tick();
        reset = 1'b0;
        tick();
        send_frame(8'd0, 8'h11, 8'd0, 784, 784);
        tick();
        chk("F_valid", {31'd0, image_valid}, 32'd1);
        chk("F_lbl0", input_labels[0], 32'h0001_0000);
        chk("F_lbl4", input_labels[4], 32'd0);
        chk("F_px270", input_data[27][0], 32'h0000_1100);

        // Index wrap 9999 -> 0 is an advance.
        send_frame(8'd4, 8'h66, 8'd0, 784, 784);
        chk("G_held_ready", {31'd0, in_ready}, 32'd0);
        input_index = 14'd0;
        tick();
        chk("wrap_lbl4", input_labels[4], 32'h0001_0000);
        chk("wrap_px00", input_data[0][0], 32'h0000_6600);
        chk("wrap_underrun", {31'd0, underrun}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
